// File: rtl/frame_painter_if.sv
// Plot-path bundle between the frame painter, its requester, the image ROM and the VGA adapter.
interface frame_painter_if #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned COLOUR_W = 3
) ();
  logic                start;
  logic [1:0]          mode;
  logic [COLOUR_W-1:0] fill_colour;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  start, mode, fill_colour, rom_q,
    output rom_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    output start, mode, fill_colour, rom_q,
    input  rom_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_painter.sv
// Full-screen raster painter: walks every pixel once per start, colouring from fill, ROM or keyed ROM.
module frame_painter #(
  parameter int unsigned H_RES       = 160,
  parameter int unsigned V_RES       = 120,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned COLOUR_W    = 3,
  parameter int unsigned ROM_LATENCY = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(3'b100)
) (
  input logic            clk,
  input logic            rst,
  frame_painter_if.master bus
);
  localparam int unsigned DRAIN_W = $clog2(ROM_LATENCY + 2);
  localparam logic [X_W-1:0]     X_LAST      = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]     Y_LAST      = Y_W'(V_RES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(ROM_LATENCY);
  localparam logic [1:0]         MODE_IMAGE  = 2'd1;
  localparam logic [1:0]         MODE_MASKED = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      cnt_x;
  logic [Y_W-1:0]      cnt_y;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [1:0]          mode_q;
  logic [COLOUR_W-1:0] fill_q;
  logic [X_W-1:0]      pipe_x [ROM_LATENCY];
  logic [Y_W-1:0]      pipe_y [ROM_LATENCY];
  logic                pipe_v [ROM_LATENCY];
  logic                accept_c;
  logic                last_pix_c;
  logic [COLOUR_W-1:0] pix_colour_c;

  assign accept_c   = (state_q == S_IDLE) && bus.start;
  assign last_pix_c = (state_q == S_RUN) && (cnt_x == X_LAST) && (cnt_y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_pix_c) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Colour of the pixel leaving the last delay stage, aligned with its rom_q.
  always_comb begin
    pix_colour_c = fill_q;
    case (mode_q)
      MODE_IMAGE:  pix_colour_c = bus.rom_q;
      MODE_MASKED: pix_colour_c = (bus.rom_q == KEY_COLOUR) ? fill_q : bus.rom_q;
      default:     pix_colour_c = fill_q;
    endcase
  end

  // Issue counters; x/y/address step together so no divide is ever needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_x        <= '0;
      cnt_y        <= '0;
      bus.rom_addr <= '0;
      mode_q       <= '0;
      fill_q       <= '0;
      drain_cnt    <= '0;
    end else begin
      if (accept_c) begin
        cnt_x        <= '0;
        cnt_y        <= '0;
        bus.rom_addr <= '0;
        mode_q       <= bus.mode;
        fill_q       <= bus.fill_colour;
      end else if ((state_q == S_RUN) && !last_pix_c) begin
        bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
        if (cnt_x == X_LAST) begin
          cnt_x <= '0;
          cnt_y <= cnt_y + Y_W'(1);
        end else begin
          cnt_x <= cnt_x + X_W'(1);
        end
      end
      drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  // Coordinate delay line matching the ROM read latency, then the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
        pipe_v[i] <= 1'b0;
      end
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      pipe_x[0] <= cnt_x;
      pipe_y[0] <= cnt_y;
      pipe_v[0] <= (state_q == S_RUN);
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
      bus.plot <= pipe_v[ROM_LATENCY-1];
      if (pipe_v[ROM_LATENCY-1]) begin
        bus.x      <= pipe_x[ROM_LATENCY-1];
        bus.y      <= pipe_y[ROM_LATENCY-1];
        bus.colour <= pix_colour_c;
      end
      bus.busy <= (state_d == S_RUN) || (state_d == S_DRAIN);
      bus.done <= (state_d == S_DONE);
    end
  end
endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter: default-size and 4x3/latency-3 instances checked against a raster model.
module tb_frame_painter;
  localparam int AH = 160, AV = 120, AN = AH * AV, AL = 1;
  localparam int BH = 4,   BV = 3,   BN = BH * BV, BL = 3;

  typedef struct { int x; int y; int c; } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_painter_if #(.X_W(8), .Y_W(7), .ADDR_W(15), .COLOUR_W(3)) bus_a ();
  frame_painter_if #(.X_W(2), .Y_W(2), .ADDR_W(4),  .COLOUR_W(3)) bus_b ();

  frame_painter #(.H_RES(AH), .V_RES(AV), .X_W(8), .Y_W(7), .ADDR_W(15), .COLOUR_W(3),
                  .ROM_LATENCY(AL), .KEY_COLOUR(3'b100))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  frame_painter #(.H_RES(BH), .V_RES(BV), .X_W(2), .Y_W(2), .ADDR_W(4), .COLOUR_W(3),
                  .ROM_LATENCY(BL), .KEY_COLOUR(3'b100))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   checks = 0;
  int   errors = 0;
  int   rom_sel = 0;
  pix_t q_a[$];
  pix_t q_b[$];

  // Image contents: 0 -> addr mod 8, 1 -> key colour at even addresses, 3 at odd
  function automatic int rom_f(input int a);
    if (rom_sel == 0) return a % 8;
    return (a % 2 == 0) ? 4 : 3;
  endfunction

  always @(posedge clk) bus_a.rom_q <= 3'(rom_f(int'(bus_a.rom_addr)));

  logic [2:0] rb1, rb2;
  always @(posedge clk) begin
    rb1         <= 3'(rom_f(int'(bus_b.rom_addr)));
    rb2         <= rb1;
    bus_b.rom_q <= rb2;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_colour(input int mode, input int fill, input int addr);
    int r;
    r = rom_f(addr);
    if (mode == 1) return r;
    if (mode == 2) return (r == 4) ? fill : r;
    return fill;
  endfunction

  task automatic push_frame(input int inst, input int mode, input int fill);
    int h, v;
    pix_t p;
    h = (inst == 0) ? AH : BH;
    v = (inst == 0) ? AV : BV;
    for (int yy = 0; yy < v; yy++)
      for (int xx = 0; xx < h; xx++) begin
        p.x = xx;
        p.y = yy;
        p.c = exp_colour(mode, fill, yy * h + xx);
        if (inst == 0) q_a.push_back(p);
        else           q_b.push_back(p);
      end
  endtask

  // Every plotted pixel is compared in order against the model queue.
  always @(negedge clk) begin
    pix_t e;
    if (bus_a.plot === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL pix_a: unexpected plot (%0d,%0d) colour %0d", bus_a.x, bus_a.y, bus_a.colour);
      end else begin
        e = q_a.pop_front();
        if (int'(bus_a.x) != e.x || int'(bus_a.y) != e.y || int'(bus_a.colour) != e.c) begin
          errors++;
          $display("FAIL pix_a: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                   bus_a.x, bus_a.y, bus_a.colour, e.x, e.y, e.c);
        end
      end
    end
    if (bus_b.plot === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL pix_b: unexpected plot (%0d,%0d) colour %0d", bus_b.x, bus_b.y, bus_b.colour);
      end else begin
        e = q_b.pop_front();
        if (int'(bus_b.x) != e.x || int'(bus_b.y) != e.y || int'(bus_b.colour) != e.c) begin
          errors++;
          $display("FAIL pix_b: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                   bus_b.x, bus_b.y, bus_b.colour, e.x, e.y, e.c);
        end
      end
    end
  end

  int w_first_k, w_last_k, w_done_k, w_plots, w_busy0, w_busy_done;
  int w_first_x, w_first_y, w_last_x, w_last_y;

  // Caller raises start just after an edge; the next edge is the accepting one (k=0).
  task automatic watch(input int inst, input bit hold, input int abort_at);
    int  budget, xx, yy;
    bit  p, d, bz;
    budget      = ((inst == 0) ? AN : BN) + 40;
    w_first_k   = -1; w_last_k = -1; w_done_k = -1; w_plots = 0; w_busy_done = -1;
    w_first_x   = -1; w_first_y = -1; w_last_x = -1; w_last_y = -1;
    @(posedge clk); #1;
    if (!hold) begin
      if (inst == 0) bus_a.start = 1'b0;
      else           bus_b.start = 1'b0;
    end
    w_busy0 = (inst == 0) ? int'(bus_a.busy) : int'(bus_b.busy);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (inst == 0) begin
        p = bus_a.plot; d = bus_a.done; bz = bus_a.busy; xx = int'(bus_a.x); yy = int'(bus_a.y);
      end else begin
        p = bus_b.plot; d = bus_b.done; bz = bus_b.busy; xx = int'(bus_b.x); yy = int'(bus_b.y);
      end
      if (p) begin
        if (w_plots == 0) begin
          w_first_k = k; w_first_x = xx; w_first_y = yy;
        end
        w_plots++;
        w_last_k = k; w_last_x = xx; w_last_y = yy;
        if (w_plots == abort_at) begin
          rst = 1'b0;
          #1;
          chk("reset_clears_outputs",
              int'(bus_a.rom_addr) + int'(bus_a.x) + int'(bus_a.y) + int'(bus_a.colour)
              + int'(bus_a.plot) + int'(bus_a.busy) + int'(bus_a.done), 0);
          return;
        end
      end
      if (d) begin
        w_done_k    = k;
        w_busy_done = int'(bz);
        return;
      end
    end
  endtask

  task automatic frame_checks(input string tag, input int n, input int lat);
    chk({tag, "_busy_after_accept"}, w_busy0, 1);
    chk({tag, "_first_plot_edge"}, w_first_k, lat + 1);
    chk({tag, "_last_plot_edge"}, w_last_k, n + lat);
    chk({tag, "_plot_count"}, w_plots, n);
    chk({tag, "_done_edge"}, w_done_k, n + lat + 1);
    chk({tag, "_busy_at_done"}, w_busy_done, 0);
    chk({tag, "_first_xy"}, w_first_x * 1000 + w_first_y, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.mode = 2'd0; bus_a.fill_colour = 3'd0;
    bus_b.start = 1'b0; bus_b.mode = 2'd0; bus_b.fill_colour = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_outputs", int'(bus_a.rom_addr) + int'(bus_a.x) + int'(bus_a.y)
        + int'(bus_a.colour) + int'(bus_a.plot) + int'(bus_a.busy) + int'(bus_a.done), 0);
    chk("reset_b_outputs", int'(bus_b.plot) + int'(bus_b.busy) + int'(bus_b.done), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: solid fill 010
    push_frame(0, 0, 2);
    bus_a.mode = 2'd0; bus_a.fill_colour = 3'd2; bus_a.start = 1'b1;
    watch(0, 1'b0, 0);
    frame_checks("t1", AN, AL);
    chk("t1_last_xy", w_last_x * 1000 + w_last_y, 159119);
    chk("t1_queue_empty", q_a.size(), 0);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", int'(bus_a.done), 0);

    // T2: image, q = addr[2:0]
    rom_sel = 0;
    push_frame(0, 1, 0);
    chk("t2_model_pix165_colour", q_a[165].c, 5);
    chk("t2_model_pix165_xy", q_a[165].x * 1000 + q_a[165].y, 5001);
    chk("t2_model_line_wrap", q_a[160].x * 1000 + q_a[160].y, 1);
    bus_a.mode = 2'd1; bus_a.start = 1'b1;
    watch(0, 1'b0, 0);
    frame_checks("t2", AN, AL);
    chk("t2_queue_empty", q_a.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // T5: reset at pixel 5000 abandons the frame
    push_frame(0, 0, 1);
    bus_a.mode = 2'd0; bus_a.fill_colour = 3'd1; bus_a.start = 1'b1;
    watch(0, 1'b0, 5000);
    chk("t5_plots_before_reset", w_plots, 5000);
    q_a.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_quiet_in_reset", int'(bus_a.plot) + int'(bus_a.done) + int'(bus_a.busy), 0);
    end
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5_no_done_after_abort", int'(bus_a.plot) + int'(bus_a.done) + int'(bus_a.busy), 0);
    end

    // T3 (also the full frame after the aborted one): masked, fill 000
    rom_sel = 1;
    push_frame(0, 2, 0);
    chk("t3_model_even", q_a[2].c, 0);
    chk("t3_model_odd", q_a[3].c, 3);
    bus_a.mode = 2'd2; bus_a.fill_colour = 3'd0; bus_a.start = 1'b1;
    watch(0, 1'b0, 0);
    frame_checks("t3", AN, AL);
    chk("t3_queue_empty", q_a.size(), 0);

    // T6: small frame, ROM latency 3, image
    rom_sel = 0;
    push_frame(1, 1, 0);
    chk("t6_model_pix4", q_b[4].x * 100 + q_b[4].y * 10 + q_b[4].c, 14);
    chk("t6_model_pix11", q_b[11].x * 100 + q_b[11].y * 10 + q_b[11].c, 323);
    bus_b.mode = 2'd1; bus_b.fill_colour = 3'd5; bus_b.start = 1'b1;
    watch(1, 1'b0, 0);
    frame_checks("t6", BN, BL);
    chk("t6_last_xy", w_last_x * 1000 + w_last_y, 3002);
    chk("t6_queue_empty", q_b.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // T4: start held, mode/fill changed mid-frame
    push_frame(1, 1, 5);
    bus_b.mode = 2'd1; bus_b.fill_colour = 3'd5; bus_b.start = 1'b1;
    fork
      begin
        repeat (6) @(posedge clk);
        #2;
        bus_b.mode = 2'd0;
        bus_b.fill_colour = 3'd6;
      end
    join_none
    watch(1, 1'b1, 0);
    frame_checks("t4a", BN, BL);
    chk("t4a_queue_empty", q_b.size(), 0);
    push_frame(1, 0, 6);
    @(posedge clk); #1;
    chk("t4_idle_gap", int'(bus_b.busy) + int'(bus_b.done) + int'(bus_b.plot), 0);
    watch(1, 1'b0, 0);
    frame_checks("t4b", BN, BL);
    chk("t4b_queue_empty", q_b.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", int'(bus_a.busy) + int'(bus_b.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
